// File: rtl/gfp8_nv_pack_if.sv
// GFP8 NV packer bus: GFP element input stream plus the packed native-vector output.
interface gfp8_nv_pack_if;
  logic               i_in_valid;
  logic               o_in_ready;
  logic signed [31:0] i_in_man;
  logic signed [7:0]  i_in_exp;
  logic               o_nv_valid;
  logic               i_nv_ready;
  logic [31:0]        o_nv_exp;
  logic [3:0][255:0]  o_nv_man;
  logic               o_overflow;
  logic               o_underflow;

  modport master (
    output i_in_valid, i_in_man, i_in_exp, i_nv_ready,
    input  o_in_ready, o_nv_valid, o_nv_exp, o_nv_man, o_overflow, o_underflow
  );

  modport slave (
    input  i_in_valid, i_in_man, i_in_exp, i_nv_ready,
    output o_in_ready, o_nv_valid, o_nv_exp, o_nv_man, o_overflow, o_underflow
  );
endinterface

// File: rtl/gfp8_nv_pack.sv
// Block-FP quantizer: packs 128 GFP elements into one GFP8 native vector (4 groups x 32 int8).
// Optional GFP8_PACK_ROUND_EN: round half away from zero on right shifts instead of truncating.
module gfp8_nv_pack #(
  parameter int EXP_BIAS = 15
) (
  input logic           i_clk,
  input logic           i_reset_n,
  gfp8_nv_pack_if.slave bus
);
  typedef enum logic [1:0] {FILL = 2'd0, NORM = 2'd1, OUT = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [6:0]         count_q, count_d;
  logic [1:0]         gidx_q, gidx_d;
  logic signed [9:0]  maxkey_q [4];
  logic signed [9:0]  maxkey_d [4];
  logic [3:0]         nz_q, nz_d;
  logic               in_ready_q, in_ready_d;
  logic               nv_valid_q, nv_valid_d;
  logic [31:0]        nv_exp_q, nv_exp_d;
  logic [3:0][255:0]  nv_man_q, nv_man_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic signed [31:0] man_mem_q [128];
  logic signed [7:0]  exp_mem_q [128];

  logic               wr_en;
  logic [31:0]        in_mag;
  logic signed [9:0]  in_key;
  logic [1:0]         in_grp;
  logic signed [9:0]  grp_e;
  logic signed [10:0] grp_biased;

  // |x| with the most negative mantissa saturated to 0x7FFFFFFF.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] man);
    if (man == 32'sh80000000) abs_mag = 32'h7FFF_FFFF;
    else if (man[31]) abs_mag = 32'd0 - man;
    else abs_mag = man;
  endfunction

  function automatic logic [4:0] msb_pos(input logic [31:0] mag);
    msb_pos = 5'd0;
    for (int i = 0; i < 31; i++) begin
      if (mag[i]) msb_pos = 5'(i);
    end
  endfunction

  function automatic logic [6:0] quant_mag(input logic [31:0] mag, input logic signed [10:0] sh);
    logic [32:0] acc;
    logic [10:0] sh_u;
    sh_u = sh;
    if (sh < 11'sd0) begin
      acc = {1'b0, mag} << (11'd0 - sh_u);
    end else if (sh > 11'sd31) begin
      acc = 33'd0;
    end else begin
`ifdef GFP8_PACK_ROUND_EN
      if (sh_u == 11'd0) acc = {1'b0, mag};
      else acc = ({1'b0, mag} + (33'd1 << (sh_u - 11'd1))) >> sh_u;
`else
      acc = {1'b0, mag} >> sh_u;
`endif
    end
    quant_mag = (acc > 33'd127) ? 7'd127 : acc[6:0];
  endfunction

  function automatic logic [7:0] lane_byte(input logic signed [31:0] man, input logic signed [7:0] exp,
                                           input logic signed [9:0] e_sh, input logic signed [10:0] biased);
    logic signed [10:0] sh;
    logic [6:0]         q;
    sh = $signed({e_sh[9], e_sh}) - $signed({{3{exp[7]}}, exp});
    q  = quant_mag(abs_mag(man), sh);
    if (man == 32'sd0 || biased < 11'sd0) lane_byte = 8'd0;
    else if (biased > 11'sd31) lane_byte = man[31] ? 8'h81 : 8'h7F;
    else if (man[31]) lane_byte = 8'd0 - {1'b0, q};
    else lane_byte = {1'b0, q};
  endfunction

  assign wr_en      = (state_q == FILL) && in_ready_q && bus.i_in_valid;
  assign in_mag     = abs_mag(bus.i_in_man);
  assign in_key     = $signed({{2{bus.i_in_exp[7]}}, bus.i_in_exp}) + $signed({5'd0, msb_pos(in_mag)});
  assign in_grp     = count_q[6:5];
  assign grp_e      = maxkey_q[gidx_q] - 10'sd6;
  assign grp_biased = $signed({grp_e[9], grp_e}) + $signed(11'(EXP_BIAS));

  // Next-state: element capture in FILL, one group normalised per NORM cycle, handshake in OUT.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    gidx_d     = gidx_q;
    maxkey_d   = maxkey_q;
    nz_d       = nz_q;
    in_ready_d = in_ready_q;
    nv_valid_d = nv_valid_q;
    nv_exp_d   = nv_exp_q;
    nv_man_d   = nv_man_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        if (wr_en) begin
          if (in_mag != 32'd0 && (!nz_q[in_grp] || in_key > maxkey_q[in_grp])) begin
            maxkey_d[in_grp] = in_key;
            nz_d[in_grp]     = 1'b1;
          end else begin
            nz_d[in_grp] = nz_q[in_grp];
          end
          if (count_q == 7'd127) begin
            state_d    = NORM;
            gidx_d     = 2'd0;
            count_d    = 7'd0;
            in_ready_d = 1'b0;
          end else begin
            count_d = count_q + 7'd1;
          end
        end else begin
          count_d = count_q;
        end
      end
      NORM: begin
        for (int k = 0; k < 32; k++) begin
          nv_man_d[gidx_q][8*k +: 8] = nz_q[gidx_q] ?
            lane_byte(man_mem_q[{gidx_q, 5'(k)}], exp_mem_q[{gidx_q, 5'(k)}], grp_e, grp_biased) : 8'd0;
        end
        // All-zero groups carry no exponent and never raise a flag.
        if (!nz_q[gidx_q] || grp_biased < 11'sd0) begin
          nv_exp_d[8*gidx_q +: 8] = 8'd0;
        end else if (grp_biased > 11'sd31) begin
          nv_exp_d[8*gidx_q +: 8] = 8'd31;
        end else begin
          nv_exp_d[8*gidx_q +: 8] = grp_biased[7:0];
        end
        ovf_d = ovf_q | (nz_q[gidx_q] && grp_biased > 11'sd31);
        unf_d = unf_q | (nz_q[gidx_q] && grp_biased < 11'sd0);
        if (gidx_q == 2'd3) begin
          state_d    = OUT;
          nv_valid_d = 1'b1;
        end else begin
          gidx_d = gidx_q + 2'd1;
        end
      end
      OUT: begin
        if (nv_valid_q && bus.i_nv_ready) begin
          state_d    = FILL;
          nv_valid_d = 1'b0;
          count_d    = 7'd0;
          in_ready_d = 1'b1;
          nz_d       = 4'd0;
          for (int g = 0; g < 4; g++) maxkey_d[g] = 10'sd0;
        end else begin
          nv_valid_d = nv_valid_q;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= FILL;
      count_q    <= 7'd0;
      gidx_q     <= 2'd0;
      nz_q       <= 4'd0;
      in_ready_q <= 1'b0;
      nv_valid_q <= 1'b0;
      nv_exp_q   <= 32'd0;
      nv_man_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int g = 0; g < 4; g++) maxkey_q[g] <= 10'sd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gidx_q     <= gidx_d;
      nz_q       <= nz_d;
      in_ready_q <= in_ready_d;
      nv_valid_q <= nv_valid_d;
      nv_exp_q   <= nv_exp_d;
      nv_man_q   <= nv_man_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      for (int g = 0; g < 4; g++) maxkey_q[g] <= maxkey_d[g];
    end
  end

  // Raw element store; contents only matter once written during FILL.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      man_mem_q[count_q] <= bus.i_in_man;
      exp_mem_q[count_q] <= bus.i_in_exp;
    end
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_nv_valid  = nv_valid_q;
  assign bus.o_nv_exp    = nv_exp_q;
  assign bus.o_nv_man    = nv_man_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
endmodule

// File: tb/tb_gfp8_nv_pack.sv
// Scoreboard bench for gfp8_nv_pack: an arithmetic reference model predicts each NV, a monitor checks the DUT.
module tb_gfp8_nv_pack;
  typedef struct {
    logic [31:0]       e;
    logic [3:0][255:0] m;
    bit                ovf;
    bit                unf;
  } nv_t;

  logic clk;
  logic rst_n;
  gfp8_nv_pack_if bus ();

  gfp8_nv_pack #(.EXP_BIAS(15)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  logic signed [31:0] man_a [128];
  logic signed [7:0]  exp_a [128];
  nv_t exp_q [$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_pushed = 0;
  int  n_seen = 0;
  int  cyc = 0;
  int  last_acc_cyc = 0;
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;
  bit  hold_rdy = 1'b0;
  bit  rand_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [255:0] got, logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic longint mag_of(logic signed [31:0] man);
    if (man == 32'sh80000000) return 64'h7FFF_FFFF;
    if (man < 0) return -longint'(man);
    return longint'(man);
  endfunction

  function automatic int flog2(longint v);
    int r;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint q_of(longint mag, int sh);
    longint q;
    if (sh < 0) q = mag * (longint'(1) << (-sh));
    else if (sh > 31) q = 0;
    else begin
`ifdef GFP8_PACK_ROUND_EN
      if (sh > 0) q = (mag + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
      else q = mag;
      if (q > 127) q = 127;
`else
      q = mag / (longint'(1) << sh);
`endif
    end
    return q;
  endfunction

  // Predict the NV for the current element arrays and queue it.
  task automatic model_push();
    nv_t x;
    x.e = '0;
    x.m = '0;
    for (int g = 0; g < 4; g++) begin
      int mk, e_sh, b, v;
      bit any;
      longint mag, q;
      mk = -100000;
      any = 1'b0;
      for (int k = 0; k < 32; k++) begin
        mag = mag_of(man_a[32*g+k]);
        if (mag != 0) begin
          any = 1'b1;
          if (int'(exp_a[32*g+k]) + flog2(mag) > mk) mk = int'(exp_a[32*g+k]) + flog2(mag);
        end
      end
      if (any) begin
        e_sh = mk - 6;
        b = e_sh + 15;
        if (b < 0) m_unf = 1'b1;
        else begin
          if (b > 31) m_ovf = 1'b1;
          x.e[8*g +: 8] = 8'((b > 31) ? 31 : b);
          for (int k = 0; k < 32; k++) begin
            mag = mag_of(man_a[32*g+k]);
            if (b > 31) q = (mag != 0) ? 127 : 0;
            else q = q_of(mag, e_sh - int'(exp_a[32*g+k]));
            v = (man_a[32*g+k] < 0) ? -int'(q) : int'(q);
            x.m[g][8*k +: 8] = 8'(v);
          end
        end
      end
    end
    x.ovf = m_ovf;
    x.unf = m_unf;
    exp_q.push_back(x);
    n_pushed++;
  endtask

  task automatic send(int n);
    int i, budget;
    bit acc;
    i = 0;
    budget = 0;
    while (i < n && budget < 5000) begin
      @(negedge clk);
      bus.i_in_valid = ($urandom_range(0, 3) != 0);
      bus.i_in_man = man_a[i];
      bus.i_in_exp = exp_a[i];
      acc = bus.i_in_valid && bus.o_in_ready;
      @(posedge clk);
      if (acc) i++;
      budget++;
    end
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    last_acc_cyc = cyc;
    if (i < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got %0d accepted want %0d", i, n);
    end
  endtask

  task automatic run_nv();
    model_push();
    send(128);
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < 128; i++) begin
      man_a[i] = 32'sd0;
      exp_a[i] = 8'sd0;
    end
  endtask

  task automatic gen_random();
    for (int g = 0; g < 4; g++) begin
      int base, e, w, r;
      bit zg;
      logic [31:0] mk;
      base = int'($urandom_range(0, 130)) - 70;
      zg = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 32; k++) begin
        r = int'($urandom_range(0, 9));
        if (zg || r == 0) man_a[32*g+k] = 32'sd0;
        else if (r == 1) man_a[32*g+k] = 32'sh80000000;
        else begin
          w = int'($urandom_range(1, 32));
          mk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
          man_a[32*g+k] = $signed($urandom & mk);
          if ($urandom_range(0, 1) == 1) man_a[32*g+k] = -man_a[32*g+k];
        end
        e = base + int'($urandom_range(0, 12)) - 6;
        if (e < -128) e = -128;
        if (e > 127) e = 127;
        exp_a[32*g+k] = 8'(e);
      end
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.o_in_ready, 1'b0);
    chk("rst_nv_valid", bus.o_nv_valid, 1'b0);
    chk("rst_nv_exp", bus.o_nv_exp, 32'd0);
    for (int g = 0; g < 4; g++) chk("rst_nv_man", bus.o_nv_man[g], 256'd0);
    chk("rst_overflow", bus.o_overflow, 1'b0);
    chk("rst_underflow", bus.o_underflow, 1'b0);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst_n = 1'b1;
    chk("rel_in_ready_low", bus.o_in_ready, 1'b0);
    @(negedge clk);
    chk("rel_in_ready_high", bus.o_in_ready, 1'b1);
  endtask

  // NV output sink: ready is changed just after the active edge.
  initial begin
    bus.i_nv_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_rdy) bus.i_nv_ready = 1'b0;
      else if (rand_rdy) bus.i_nv_ready = ($urandom_range(0, 2) != 0);
      else bus.i_nv_ready = 1'b1;
    end
  end

  // Monitor: every cycle an NV is presented it must equal the scoreboard head.
  initial begin
    bit prev_valid;
    nv_t x;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_nv_valid) begin
        if (!prev_valid) begin
          n_cmp++;
          if (cyc - last_acc_cyc < 4 || cyc - last_acc_cyc > 5) begin
            n_err++;
            $display("FAIL valid_latency: got %0d cycles want 4..5", cyc - last_acc_cyc);
          end
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_nv: got nv_valid=1 want no pending NV");
        end else begin
          x = exp_q[0];
          chk("nv_exp", bus.o_nv_exp, x.e);
          for (int g = 0; g < 4; g++) chk("nv_man_group", bus.o_nv_man[g], x.m[g]);
          chk("overflow", bus.o_overflow, x.ovf);
          chk("underflow", bus.o_underflow, x.unf);
          chk("in_ready_while_out", bus.o_in_ready, 1'b0);
          if (bus.i_nv_ready) begin
            void'(exp_q.pop_front());
            n_seen++;
          end
        end
      end
      prev_valid = rst_n && bus.o_nv_valid;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_man = 32'sd0;
    bus.i_in_exp = 8'sd0;
    do_reset();

    clear_arrays();
    for (int i = 0; i < 128; i++) man_a[i] = 32'sd1;
    run_nv();

    clear_arrays();
    man_a[0] = 32'sd100;
    man_a[1] = -32'sd100;
    man_a[2] = 32'sd3;
    exp_a[2] = -8'sd1;
    run_nv();

    clear_arrays();
    run_nv();
    wait_drain();
    chk("flags_clean_ovf", bus.o_overflow, 1'b0);
    chk("flags_clean_unf", bus.o_underflow, 1'b0);

    clear_arrays();
    for (int k = 0; k < 32; k++) begin
      man_a[32+k] = 32'sd1;
      exp_a[32+k] = -8'sd40;
      man_a[64+k] = 32'sh7FFFFFFF;
      exp_a[64+k] = 8'sd30;
    end
    run_nv();

    rand_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      gen_random();
      run_nv();
    end
    wait_drain();
    rand_rdy = 1'b0;

    hold_rdy = 1'b1;
    gen_random();
    run_nv();
    for (int b = 0; b < 200 && !bus.o_nv_valid; b++) @(negedge clk);
    chk("hold_valid_seen", bus.o_nv_valid, 1'b1);
    repeat (10) @(negedge clk);
    chk("hold_still_pending", exp_q.size(), 1);
    hold_rdy = 1'b0;
    gen_random();
    run_nv();
    wait_drain();

    gen_random();
    send(50);
    do_reset();
    rand_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      gen_random();
      run_nv();
    end
    wait_drain();
    repeat (20) @(negedge clk);
    chk("nv_count", n_seen, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
